// File: rtl/fetch_sequencer_if.sv
// Memory/cache port of the fetch sequencer: instruction fetch and data access handshakes.
// The master side is the sequencer and the slave side is the memory or cache.
interface fetch_sequencer_if;
    logic        ihit;      // instruction word returned this cycle
    logic [31:0] imemload;  // instruction word, valid with ihit
    logic        dhit;      // pending data read/write completed this cycle
    logic [31:0] imemaddr;  // current PC
    logic        iREN;      // instruction read request
    logic        dREN;      // data read request, held until dhit
    logic        dWEN;      // data write request, held until dhit

    modport master (
        input  ihit, imemload, dhit,
        output imemaddr, iREN, dREN, dWEN
    );

    modport slave (
        output ihit, imemload, dhit,
        input  imemaddr, iREN, dREN, dWEN
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/sequencing stage in front of the control unit.
// Owns the PC and the latched instruction. It walks each instruction through FETCH, EXEC
// and an optional MEM wait, then selects the next PC from the control unit's pcmode.
// A halt instruction parks it in HALTED until reset.
module fetch_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic                      CLK,
    input  logic                      RST,
    fetch_sequencer_if.master         memPort,
    input  logic                      cu_iREN,
    input  logic                      cu_dREN,
    input  logic                      cu_dWEN,
    input  logic                      cu_halt,
    input  logic [1:0]                pcmode,
    input  logic                      branch_taken,
    input  logic [31:0]               rs_data,
    output logic [31:0]               instr,
    output logic [5:0]                op,
    output logic [5:0]                funct,
    output logic [31:0]               pc_plus4,
    output logic                      wb_en,
    output logic                      halt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } seqState_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JR     = 2'b11
    } pcMode_e;

    seqState_e   state;
    seqState_e   nextState;
    logic [31:0] pcReg;
    logic [31:0] instrReg;
    logic        iStall;      // last retire had cu_iREN=0; hold off fetching
    logic [31:0] nextPc;
    logic [31:0] branchOffset;
    logic [31:0] jumpTarget;
    logic        retire;      // instruction completes this cycle
    logic        fetchTake;   // capture imemload this cycle
    logic        iRenComb;
    logic        dRenComb;
    logic        dWenComb;
    logic        memAccess;

    assign memAccess = cu_dREN | cu_dWEN;

    // Architectural state: PC, latched instruction, FSM state and fetch-stall flag.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (RST) begin
            state    <= FETCH;
            pcReg    <= PC_INIT;
            instrReg <= '0;
            iStall   <= 1'b0;
        end else begin
            state <= nextState;
            if (fetchTake) begin
                instrReg <= memPort.imemload;
            end
            if (retire) begin
                pcReg  <= nextPc;
                iStall <= ~cu_iREN;
            end else if (state == FETCH && cu_iREN) begin
                iStall <= 1'b0;
            end
        end
    end

    // Next-state decode and per-state request/strobe outputs; reset forces them all low.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nextState = state;
        iRenComb  = 1'b0;
        dRenComb  = 1'b0;
        dWenComb  = 1'b0;
        retire    = 1'b0;
        fetchTake = 1'b0;

        unique case (state)
            FETCH: begin
                iRenComb = ~iStall | cu_iREN;
                if (iRenComb && memPort.ihit) begin
                    fetchTake = 1'b1;
                    nextState = EXEC;
                end
            end
            EXEC: begin
                if (cu_halt) begin
                    nextState = HALTED;
                end else if (memAccess) begin
                    nextState = MEM;
                end else begin
                    retire    = 1'b1;
                    nextState = FETCH;
                end
            end
            MEM: begin
                // Pass both enables straight through, even the illegal 11 combination.
                dRenComb = cu_dREN;
                dWenComb = cu_dWEN;
                if (memPort.dhit) begin
                    retire    = 1'b1;
                    nextState = FETCH;
                end
            end
            HALTED: begin
                nextState = HALTED;
            end
            default: begin
                nextState = FETCH;
            end
        endcase

        if (RST) begin
            iRenComb  = 1'b0;
            dRenComb  = 1'b0;
            dWenComb  = 1'b0;
            retire    = 1'b0;
            fetchTake = 1'b0;
        end
    end

    // Next-PC selection from the latched instruction and the control unit's pcmode.
    always_comb begin
        branchOffset = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
        jumpTarget   = {pc_plus4[31:28], instrReg[25:0], 2'b00};
        nextPc       = pc_plus4;
        unique case (pcMode_e'(pcmode))
            PC_SEQ:    nextPc = pc_plus4;
            PC_BRANCH: nextPc = branch_taken ? (pc_plus4 + branchOffset) : pc_plus4;
            PC_JUMP:   nextPc = jumpTarget;
            PC_JR:     nextPc = rs_data;
            default:   nextPc = pc_plus4;
        endcase
    end

    assign pc_plus4 = pcReg + 32'd4;

    assign memPort.imemaddr = pcReg;
    assign memPort.iREN     = iRenComb;
    assign memPort.dREN     = dRenComb;
    assign memPort.dWEN     = dWenComb;

    assign instr = instrReg;
    assign op    = instrReg[31:26];
    assign funct = instrReg[5:0];
    assign wb_en = retire;
    assign halt  = (state == HALTED);

    // The PC moves only on a retiring cycle.
    pcOnlyOnRetire: assert property (@(posedge CLK) disable iff (RST)
        !retire |=> $stable(pcReg));

    // HALTED is left only through reset.
    haltIsSticky: assert property (@(posedge CLK) disable iff (RST)
        (state == HALTED) |=> (state == HALTED));

    // Data requests never appear outside MEM.
    dataReqOnlyInMem: assert property (@(posedge CLK) disable iff (RST)
        (state != MEM) |-> !(dRenComb || dWenComb));

endmodule
